// File: rtl/cs_out_fifo.sv
// -----------------------------------------------------------------------------
// cs_out_fifo
//
// Output buffer stage behind the CS core. Samples the core result `y` on every
// rising edge. It discards the first WARMUP samples after reset release, because
// the core's sample window is still filling during that time. It then queues
// every later sample in a first-word-fall-through FIFO. Entries leave through a
// valid/ready handshake.
//
// Optional feature macro: CS_OUT_FIFO_DROP_CNT_EN
//   defined   -> 8-bit saturating drop counter drives drop_cnt
//   undefined -> no counter register, drop_cnt tied to 0
//
// Parameters:
//   WIDTH  - data width (matches CS.Y)
//   DEPTH  - FIFO entries, power of two, >= 2
//   WARMUP - edges after reset release whose sample is discarded (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   y          in   sample from the core
//   flush      in   synchronous clear of queue, overflow flag and drop counter
//   dout       out  head-of-queue data (0 while the queue is empty)
//   dout_valid out  dout holds a queued entry
//   dout_ready in   consumer takes dout at this edge
//   count      out  number of queued entries
//   full       out  count == DEPTH
//   overflow   out  sticky: a sample was dropped because the queue was full
//   drop_cnt   out  saturating count of dropped samples
// -----------------------------------------------------------------------------
module cs_out_fifo #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       y,
    input  logic                   flush,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(WARMUP + 1);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_warm_cnt;
    logic [WCW-1:0]   w_warm_cnt_nxt;
    logic             w_wr_req;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_overflow;

    logic             w_full;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;

    // Warm-up FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_WARM;
            r_warm_cnt <= {WCW{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    // Warm-up FSM next state. The switch to RUN happens on edge WARMUP itself,
    // so edge WARMUP+1 is already in RUN and produces the first write request.
    always_comb begin
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        w_wr_req       = 1'b0;
        case (r_state)
            ST_WARM: begin
                w_warm_cnt_nxt = r_warm_cnt + WCW'(1);
                if (r_warm_cnt == WCW'(WARMUP - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_WARM;
                end
            end
            ST_RUN: begin
                w_wr_req    = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt    = ST_WARM;
                w_warm_cnt_nxt = {WCW{1'b0}};
            end
        endcase
    end

    // Handshake decode. When the queue is full, a write is still accepted if a
    // pop happens in the same cycle, because the pop frees a slot.
    always_comb begin
        w_full      = (r_count == CW'(DEPTH));
        w_rd        = dout_valid & dout_ready;
        w_wr        = w_wr_req & (~w_full | w_rd);
        w_drop      = w_wr_req & w_full & ~w_rd;
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array. It has no reset. A flush suppresses the write.
    always_ff @(posedge clk) begin
        if (w_wr && !flush) begin
            r_mem[r_wr_ptr] <= y;
        end
    end

    // Pointers, occupancy and sticky overflow flag. Flush outranks read and write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

`ifdef CS_OUT_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating drop counter. A write ignored because of flush is not a drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= 8'd0;
        end else if (flush) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'd0;
`endif

    // All outputs decode from registers only. dout is forced to 0 while the
    // queue is empty, so the output reads 0 after reset even though the
    // storage array is not cleared.
    assign dout_valid = (r_count != {CW{1'b0}});
    assign dout       = dout_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
    assign count      = r_count;
    assign full       = w_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_cs_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_cs_out_fifo
//
// Directed bench for cs_out_fifo. A queue-based reference model is updated on
// every rising edge from the bench's own stimulus. A compare process checks all
// outputs against the model on every falling edge. Literal expectations at key
// points pin the model itself.
// -----------------------------------------------------------------------------
module tb_cs_out_fifo;

    localparam int WIDTH  = 10;
    localparam int DEPTH  = 16;
    localparam int WARMUP = 9;
    localparam int CW     = $clog2(DEPTH) + 1;

`ifdef CS_OUT_FIFO_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic [WIDTH-1:0] y          = '0;
    logic             flush      = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    cs_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .WARMUP(WARMUP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .y         (y),
        .flush     (flush),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf   = 1'b0;
    int               m_drops = 0;
    int               m_edges = 0;
    logic [WIDTH-1:0] yv      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        m_edges = 0;
    endtask

    // One rising edge, expressed as the buffer's rules rather than its circuit.
    task automatic model_edge();
        bit rd;
        bit acc;
        if (reset) begin
            m_edges++;
            if (flush) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
            end else begin
                rd  = (m_q.size() != 0) && dout_ready;
                acc = 1'b0;
                if (m_edges > WARMUP) begin
                    if ((m_q.size() < DEPTH) || rd) begin
                        acc = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                if (rd)  void'(m_q.pop_front());
                if (acc) m_q.push_back(y);
            end
        end
    endtask

    // Advance one clock and update the model. Then move y to its next value,
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        yv = yv + 1'b1;
        y  = yv;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        yv    = '0;
        y     = '0;
        m_edges = 0;
    endtask

    // After release with ready high, edges 1..9 discard, and edge 10 brings 9 to the head.
    task automatic warm_check();
        dout_ready = 1'b1;
        repeat (WARMUP) tick();
        check("warm_no_valid_e9", 32'(dout_valid), 32'd0);
        tick();
        check("first_valid_e10", 32'(dout_valid), 32'd1);
        check("first_data_e10", 32'(dout), 32'd9);
        check("first_count_e10", 32'(count), 32'd1);
        tick();
        check("track_e11", 32'(dout), 32'd10);
        tick();
        check("track_e12", 32'(dout), 32'd11);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_valid", 32'(dout_valid), 32'(m_q.size() != 0));
            check("cmp_count", 32'(count), 32'(m_q.size()));
            check("cmp_full", 32'(full), 32'(m_q.size() == DEPTH));
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
            check("cmp_drop_cnt", 32'(drop_cnt), DROP_EN ? 32'(m_drops) : 32'd0);
            if (m_q.size() != 0) check("cmp_dout", 32'(dout), 32'(m_q[0]));
        end
    end

    initial begin
        logic [WIDTH-1:0] exp_y;
        model_clear();
        reset = 1'b0;
        repeat (3) tick();
        #1;
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_count", 32'(count), 32'd0);

        // Warm-up discard and one-cycle tracking.
        release_reset();
        warm_check();
        repeat (5) tick();

        // Fresh start with the consumer stalled.
        reset = 1'b0;
        model_clear();
        dout_ready = 1'b0;
        tick();
        release_reset();
        repeat (25) tick();
        check("fill_count", 32'(count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        repeat (4) tick();
        check("drop4_ovf", 32'(overflow), 32'd1);
        check("drop4_cnt", 32'(drop_cnt), DROP_EN ? 32'd4 : 32'd0);
        check("drop4_count", 32'(count), 32'd16);

        // Release ready: the first 16 samples leave in order.
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_order", 32'(dout), 32'(9 + i));
            tick();
        end

        // Queue now holds 29..44. Drop one sample, then do a single pop+write.
        dout_ready = 1'b0;
        tick();
        check("drop5_cnt", 32'(drop_cnt), DROP_EN ? 32'd5 : 32'd0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("popwr_count", 32'(count), 32'd16);
        check("popwr_drop", 32'(drop_cnt), DROP_EN ? 32'd5 : 32'd0);
        check("popwr_head", 32'(dout), 32'd30);

        // Long stall: the drop counter saturates at 255.
        repeat (252) tick();
        check("sat_cnt", 32'(drop_cnt), DROP_EN ? 32'd255 : 32'd0);
        tick();
        check("sat_hold", 32'(drop_cnt), DROP_EN ? 32'd255 : 32'd0);

        // Drain: 30..44, then the sample written during the pop+write cycle.
        dout_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("tail_order", 32'(dout), 32'(30 + i));
            tick();
        end
        check("tail_new", 32'(dout), 32'd46);
        tick();

        // Flush while full and overflowed.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dout_ready = 1'b0;
        check("flush1_count", 32'(count), 32'd0);
        check("flush1_ovf", 32'(overflow), 32'd0);
        check("flush1_drop", 32'(drop_cnt), 32'd0);
        exp_y = y;
        tick();
        check("post_flush_write", 32'(count), 32'd1);
        check("post_flush_data", 32'(dout), 32'(exp_y));
        repeat (4) tick();
        check("five_queued", 32'(count), 32'd5);

        // Flush with 5 entries queued, a write pending and ready high.
        flush = 1'b1;
        dout_ready = 1'b1;
        tick();
        flush = 1'b0;
        dout_ready = 1'b0;
        check("flush2_count", 32'(count), 32'd0);
        check("flush2_valid", 32'(dout_valid), 32'd0);
        check("flush2_ovf", 32'(overflow), 32'd0);
        check("flush2_drop", 32'(drop_cnt), 32'd0);
        tick();
        check("still_run", 32'(count), 32'd1);
        repeat (6) tick();
        check("seven_queued", 32'(count), 32'd7);

        // Half-cycle reset pulse in RUN.
        reset = 1'b0;
        model_clear();
        #1;
        check("midrst_valid", 32'(dout_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        #3;
        release_reset();
        warm_check();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
